// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC types: condition codes, opcodes, flag indices, sequencer states
package wisc_pkg;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_UN = 3'b111
  } cond_e;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    PC_FETCH = 2'd0,
    PC_DRAIN = 2'd1,
    PC_HALT  = 2'd2
  } pc_seq_state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch condition evaluation from C[2:0] and {Z,V,N}
module cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);

  logic z, v, n;
  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign n = flags_i[FLAG_N];

  // decode the condition code against the current flags
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_NE: taken_o = ~z;
      COND_EQ: taken_o = z;
      COND_GT: taken_o = ~z & ~n;
      COND_LT: taken_o = n;
      COND_GE: taken_o = z | ~n;
      COND_LE: taken_o = z | n;
      COND_OV: taken_o = v;
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer; PC_SEQ_PERF_EN adds perf counters
module pc_sequencer
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_valid,
  input  logic        br_is_reg,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_reg,
  input  logic [15:0] br_pc_plus2,
  input  logic [2:0]  flags,
  input  logic        flag_pend,
  input  logic        halt_id,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        flush_ifid,
  output logic        br_stall,
  output logic        halted
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0] perf_br_taken,
  output logic [15:0] perf_stall
`endif
);

  pc_seq_state_e state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   req_addr_q, req_addr_d;
  logic          drain_halt_q, drain_halt_d;
  logic          taken;
  logic          br_taken;
  logic [15:0]   target;

  cond_eval u_cond_eval (
    .cond_i  (br_cond),
    .flags_i (flags),
    .taken_o (taken)
  );

  // immediate offset is in words, so it is shifted left by one before the add
  assign target = br_is_reg ? br_reg
                            : br_pc_plus2 + {{6{br_imm[8]}}, br_imm, 1'b0};

  // next-state and output decode; every output forced low while in reset
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    drain_halt_d = drain_halt_q;
    imem_req     = 1'b0;
    imem_addr    = 16'h0000;
    if_valid     = 1'b0;
    if_instr     = 16'h0000;
    if_pc_plus2  = 16'h0000;
    flush_ifid   = 1'b0;
    br_stall     = 1'b0;
    halted       = 1'b0;
    br_taken     = 1'b0;
    if (rst_n) begin
      if_instr    = imem_data;
      if_pc_plus2 = pc_q + 16'd2;
      case (state_q)
        PC_FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          if (halt_id && !stall_i) begin
            flush_ifid = 1'b1;
            if (imem_rdy) begin
              state_d = PC_HALT;
            end else begin
              state_d      = PC_DRAIN;
              req_addr_d   = pc_q;
              drain_halt_d = 1'b1;
            end
          end else if (stall_i) begin
            // held; any data returning now is dropped and fetched again
          end else if (br_valid && flag_pend) begin
            br_stall = 1'b1;
          end else if (br_valid && taken) begin
            br_taken   = 1'b1;
            flush_ifid = 1'b1;
            pc_d       = target;
            if (!imem_rdy) begin
              state_d      = PC_DRAIN;
              req_addr_d   = pc_q;
              drain_halt_d = 1'b0;
            end
          end else if (imem_rdy) begin
            if_valid = 1'b1;
            pc_d     = pc_q + 16'd2;
          end
        end
        PC_DRAIN: begin
          // the outstanding request must complete before the new address goes out
          imem_req  = 1'b1;
          imem_addr = req_addr_q;
          if (imem_rdy) begin
            state_d = drain_halt_q ? PC_HALT : PC_FETCH;
          end
        end
        default: begin
          imem_addr = pc_q;
          halted    = 1'b1;
        end
      endcase
    end
  end

  // state, pc and drain bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PC_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= 16'h0000;
      drain_halt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      drain_halt_q <= drain_halt_d;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [15:0] perf_br_taken_q;
  logic [15:0] perf_stall_q;
  logic        stall_evt;

  assign stall_evt     = stall_i | br_stall | (imem_req & ~imem_rdy);
  assign perf_br_taken = rst_n ? perf_br_taken_q : 16'h0000;
  assign perf_stall    = rst_n ? perf_stall_q : 16'h0000;

  // saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_br_taken_q <= 16'h0000;
      perf_stall_q    <= 16'h0000;
    end else begin
      if (br_taken && perf_br_taken_q != 16'hFFFF) begin
        perf_br_taken_q <= perf_br_taken_q + 16'd1;
      end
      if (stall_evt && perf_stall_q != 16'hFFFF) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, br_valid, br_is_reg;
  logic [2:0]  br_cond;
  logic [8:0]  br_imm;
  logic [15:0] br_reg, br_pc_plus2;
  logic [2:0]  flags;
  logic        flag_pend, halt_id, imem_rdy;
  logic [15:0] imem_data;
  logic        imem_req, if_valid, flush_ifid, br_stall, halted;
  logic [15:0] imem_addr, if_instr, if_pc_plus2;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] perf_br_taken, perf_stall;
`endif

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .br_valid    (br_valid),
    .br_is_reg   (br_is_reg),
    .br_cond     (br_cond),
    .br_imm      (br_imm),
    .br_reg      (br_reg),
    .br_pc_plus2 (br_pc_plus2),
    .flags       (flags),
    .flag_pend   (flag_pend),
    .halt_id     (halt_id),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .flush_ifid  (flush_ifid),
    .br_stall    (br_stall),
    .halted      (halted)
`ifdef PC_SEQ_PERF_EN
    ,
    .perf_br_taken (perf_br_taken),
    .perf_stall    (perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: mode 0 = fetching, 1 = waiting out an old request, 2 = halted
  int          m_mode, n_mode;
  logic [15:0] m_pc, n_pc, m_req, n_req;
  bit          m_dh, n_dh;
  bit          e_req, e_ifv, e_flush, e_brs, e_halt, e_tk;
  logic [15:0] e_addr, e_instr, e_pc2;
  int          m_ptk, m_pst;

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    if (c == 3'd0) return !z;
    if (c == 3'd1) return z;
    if (c == 3'd2) return !z && !n;
    if (c == 3'd3) return n;
    if (c == 3'd4) return z || !n;
    if (c == 3'd5) return z || n;
    if (c == 3'd6) return v;
    return 1'b1;
  endfunction

  function automatic logic [15:0] branch_target();
    int off;
    if (br_is_reg) return br_reg;
    off = br_imm[8] ? int'(br_imm) - 512 : int'(br_imm);
    return 16'((int'(br_pc_plus2) + 2 * off) & 32'hFFFF);
  endfunction

  task automatic model_eval();
    n_mode = m_mode; n_pc = m_pc; n_req = m_req; n_dh = m_dh;
    e_req = 0; e_ifv = 0; e_flush = 0; e_brs = 0; e_halt = 0; e_tk = 0;
    e_addr = 16'h0; e_instr = 16'h0; e_pc2 = 16'h0;
    if (!rst_n) begin
      n_mode = 0; n_pc = 16'h0000; n_dh = 0; n_req = 16'h0000;
      return;
    end
    e_instr = imem_data;
    e_pc2   = 16'((int'(m_pc) + 2) % 65536);
    if (m_mode == 0) begin
      e_req = 1; e_addr = m_pc;
      if (halt_id && !stall_i) begin
        e_flush = 1;
        if (imem_rdy) n_mode = 2;
        else begin n_mode = 1; n_dh = 1; n_req = m_pc; end
      end else if (stall_i) begin
        n_pc = m_pc;
      end else if (br_valid && flag_pend) begin
        e_brs = 1;
      end else if (br_valid && cond_true(br_cond, flags)) begin
        e_flush = 1; e_tk = 1; n_pc = branch_target();
        if (!imem_rdy) begin n_mode = 1; n_dh = 0; n_req = m_pc; end
      end else if (imem_rdy) begin
        e_ifv = 1; n_pc = e_pc2;
      end
    end else if (m_mode == 1) begin
      e_req = 1; e_addr = m_req;
      if (imem_rdy) n_mode = m_dh ? 2 : 0;
    end else begin
      e_halt = 1; e_addr = m_pc;
    end
  endtask

  // settle, compare every output with the model, then advance one clock
  task automatic step();
    #1;
    model_eval();
    check("imem_req",    16'(imem_req),    16'(e_req));
    check("imem_addr",   imem_addr,        e_addr);
    check("if_valid",    16'(if_valid),    16'(e_ifv));
    check("if_instr",    if_instr,         e_instr);
    check("if_pc_plus2", if_pc_plus2,      e_pc2);
    check("flush_ifid",  16'(flush_ifid),  16'(e_flush));
    check("br_stall",    16'(br_stall),    16'(e_brs));
    check("halted",      16'(halted),      16'(e_halt));
`ifdef PC_SEQ_PERF_EN
    check("perf_br_taken", perf_br_taken, rst_n ? 16'(m_ptk) : 16'h0);
    check("perf_stall",    perf_stall,    rst_n ? 16'(m_pst) : 16'h0);
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_ptk = 0; m_pst = 0;
    end else begin
      if (e_tk && m_ptk < 65535) m_ptk++;
      if ((stall_i || e_brs || (e_req && !imem_rdy)) && m_pst < 65535) m_pst++;
    end
    m_mode = n_mode; m_pc = n_pc; m_req = n_req; m_dh = n_dh;
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; br_valid = 0; br_is_reg = 0; br_cond = 3'd0; br_imm = 9'd0;
    br_reg = 16'h0; br_pc_plus2 = 16'h0; flags = 3'd0; flag_pend = 0;
    halt_id = 0; imem_rdy = 0; imem_data = 16'h0;
  endtask

  task automatic jump_reg(input logic [15:0] addr);
    br_valid = 1; br_is_reg = 1; br_cond = 3'd7; br_reg = addr; imem_rdy = 1;
    step();
    br_valid = 0;
  endtask

  initial begin
    m_mode = 0; m_pc = 16'h0; m_req = 16'h0; m_dh = 0; m_ptk = 0; m_pst = 0;
    rst_n = 0;
    idle_inputs();
    imem_data = 16'hA5A5;
    step();
    step();

    // continuous hits from reset
    rst_n = 1; imem_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      imem_data = 16'($urandom);
      #1;
      check("hit_addr", imem_addr, 16'(2 * i));
      check("hit_valid", 16'(if_valid), 16'h1);
      step();
    end

    // B, EQ with Z set: 0010 + (-2 << 1) = 000C
    br_valid = 1; br_is_reg = 0; br_cond = 3'd1; flags = 3'b100;
    br_pc_plus2 = 16'h0010; br_imm = 9'h1FE;
    #1; check("b_flush", 16'(flush_ifid), 16'h1);
    step();
    br_valid = 0; flags = 3'b000;
    #1; check("b_target", imem_addr, 16'h000C);
    step();

    // BR taken while a miss is outstanding
    imem_rdy = 0;
    step();
    br_valid = 1; br_is_reg = 1; br_cond = 3'd7; br_reg = 16'h1234;
    step();
    br_valid = 0;
    for (int i = 0; i < 3; i++) begin
      imem_rdy = (i == 2);
      #1;
      check("drain_addr", imem_addr, 16'h000E);
      check("drain_valid", 16'(if_valid), 16'h0);
      step();
    end
    imem_rdy = 1;
    #1; check("br_target", imem_addr, 16'h1234);
    step();

    // GT branch held by flag_pend for three cycles
    br_valid = 1; br_is_reg = 0; br_cond = 3'd2; flags = 3'b000;
    br_pc_plus2 = 16'h0100; br_imm = 9'h004; flag_pend = 1;
    for (int i = 0; i < 3; i++) begin
      #1; check("fp_br_stall", 16'(br_stall), 16'h1);
      step();
    end
    flag_pend = 0;
    #1;
    check("fp_br_stall_drop", 16'(br_stall), 16'h0);
    check("fp_flush", 16'(flush_ifid), 16'h1);
    step();
    br_valid = 0;
    #1; check("fp_target", imem_addr, 16'h0108);
    step();

    // stall_i together with a taken branch
    stall_i = 1; br_valid = 1; br_is_reg = 1; br_cond = 3'd7; br_reg = 16'h2000;
    for (int i = 0; i < 2; i++) begin
      #1; check("stall_no_flush", 16'(flush_ifid), 16'h0);
      step();
    end
    stall_i = 0;
    #1; check("stall_release_flush", 16'(flush_ifid), 16'h1);
    step();
    br_valid = 0;
    #1; check("stall_target", imem_addr, 16'h2000);
    step();

    // pc wraps from FFFE to 0000
    jump_reg(16'hFFFE);
    step();
    #1; check("wrap_addr", imem_addr, 16'h0000);
    step();

    // halt at 0040, then reset
    jump_reg(16'h0040);
    halt_id = 1;
    #1; check("halt_pc", imem_addr, 16'h0040);
    step();
    halt_id = 0;
    for (int i = 0; i < 3; i++) begin
      br_valid = 1; br_cond = 3'd7; imem_rdy = 1'($urandom);
      #1;
      check("halt_halted", 16'(halted), 16'h1);
      check("halt_no_req", 16'(imem_req), 16'h0);
      step();
    end
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1; imem_rdy = 1;
    #1; check("post_halt_reset", imem_addr, 16'h0000);
    step();

    // randomized traffic, with occasional halts and resets
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      stall_i     = ($urandom_range(0, 5) == 0);
      br_valid    = ($urandom_range(0, 3) == 0);
      br_is_reg   = 1'($urandom);
      br_cond     = 3'($urandom);
      br_imm      = 9'($urandom);
      br_reg      = 16'($urandom);
      br_pc_plus2 = 16'($urandom);
      flags       = 3'($urandom);
      flag_pend   = ($urandom_range(0, 4) == 0);
      halt_id     = ($urandom_range(0, 39) == 0);
      imem_rdy    = ($urandom_range(0, 3) != 0);
      imem_data   = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
